// File: rtl/menu_pkg.sv
// Shared types and constants for the parametrised vending-menu controller.
package menu_pkg;

    // Two-hot-free one-hot encoding so a corrupted state is caught by the default arm.
    typedef enum logic [1:0] {
        BROWSE = 2'b01,
        GRANT  = 2'b10
    } state_t;

    localparam int DEFAULT_ITEMS = 4;
    localparam int DEFAULT_MW    = 6;
    localparam logic [DEFAULT_ITEMS*DEFAULT_MW-1:0] DEFAULT_PRICES =
        {6'd25, 6'd30, 6'd40, 6'd45};

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/button_cond.sv
// Synchronises raw button levels, samples them on the tick and emits one pulse per press edge.
module button_cond #(
    parameter int W     = 3,
    parameter int CNT_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] tick_cnt,
    input  logic [W-1:0]     pressed,
    output logic [W-1:0]     evt
);

    logic [W-1:0] sync1, sync2, hist;
    logic         tick;

    assign tick = &tick_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= pressed;
            sync2 <= sync1;
            if (tick)
                hist <= sync2;
        end
    end

    // History advances on every tick, so a held button can only fire once.
    assign evt = tick ? (sync2 & ~hist) : '0;

endmodule

// File: rtl/menu_select_n.sv
// Menu navigation and vend-grant FSM with a valid/ack hand-off to the dispenser.
module menu_select_n
    import menu_pkg::*;
#(
    parameter int N_ITEMS   = 4,
    parameter int MONEY_W   = 6,
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICES = DEFAULT_PRICES,
    parameter int TICK_BITS = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cima,
    input  logic               baixo,
    input  logic               enter,
    input  logic [MONEY_W-1:0] saldo_in,
    input  logic               vend_ack,
    output logic [N_ITEMS-1:0] menu_option,
    output logic               vend_valid,
    output logic [N_ITEMS-1:0] vend_item,
    output logic [MONEY_W-1:0] gasto_out,
    output logic [MONEY_W-1:0] troco_out,
    output logic               deny
);

    localparam int IDX_W = $clog2(N_ITEMS);

    state_t               state;
    logic [TICK_BITS-1:0] tick_cnt;
    logic [IDX_W-1:0]     index, idx_up, idx_dn;
    logic [2:0]           evt;
    logic [MONEY_W-1:0]   price_tbl [N_ITEMS];
    logic [MONEY_W-1:0]   price_sel;

    always_ff @(posedge clock) begin
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick_cnt + 1'b1;
    end

    // Buttons normalised to active-high before synchronisation: {enter, baixo, cima}.
    button_cond #(.W(3), .CNT_W(TICK_BITS)) u_btn (
        .clock    (clock),
        .reset    (reset),
        .tick_cnt (tick_cnt),
        .pressed  ({enter, ~baixo, ~cima}),
        .evt      (evt)
    );

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_price
        assign price_tbl[i] = PRICES[i*MONEY_W +: MONEY_W];
    end

    assign price_sel = price_tbl[index];
    assign idx_up    = (index == IDX_W'(N_ITEMS-1)) ? '0 : index + 1'b1;
    assign idx_dn    = (index == '0) ? IDX_W'(N_ITEMS-1) : index - 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= BROWSE;
            index       <= '0;
            menu_option <= N_ITEMS'(1);
            vend_valid  <= 1'b0;
            vend_item   <= '0;
            gasto_out   <= '0;
            troco_out   <= '0;
            deny        <= 1'b0;
        end else begin
            deny <= 1'b0;
            case (state)
                BROWSE: begin
                    if (evt[0]) begin
                        index       <= idx_up;
                        menu_option <= N_ITEMS'(onehot(4'(idx_up)));
                    end else if (evt[1]) begin
                        index       <= idx_dn;
                        menu_option <= N_ITEMS'(onehot(4'(idx_dn)));
                    end else if (evt[2]) begin
                        if (saldo_in >= price_sel) begin
                            vend_valid <= 1'b1;
                            vend_item  <= N_ITEMS'(onehot(4'(index)));
                            gasto_out  <= price_sel;
                            troco_out  <= saldo_in - price_sel;
                            state      <= GRANT;
                        end else begin
                            deny <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    if (vend_ack) begin
                        vend_valid <= 1'b0;
                        vend_item  <= '0;
                        gasto_out  <= '0;
                        troco_out  <= '0;
                        state      <= BROWSE;
                    end
                end
                default: begin
                    vend_valid <= 1'b0;
                    vend_item  <= '0;
                    gasto_out  <= '0;
                    troco_out  <= '0;
                    state      <= BROWSE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_select_n.sv
// Directed plus randomised checks of menu_select_n against a simple item/price model.
module tb_menu_select_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cima = 1'b1, baixo = 1'b1, enter = 1'b0;
    logic [5:0] saldo_in = '0;
    logic       vend_ack = 1'b0;
    logic [3:0] menu_option, vend_item;
    logic       vend_valid, deny;
    logic [5:0] gasto_out, troco_out;

    int tests = 0, failed = 0;
    int deny_cnt = 0;
    int idx_m = 0;
    int price_m [4] = '{45, 40, 30, 25};

    menu_select_n #(.N_ITEMS(4), .MONEY_W(6), .TICK_BITS(2)) dut (
        .clock(clock), .reset(reset), .cima(cima), .baixo(baixo), .enter(enter),
        .saldo_in(saldo_in), .vend_ack(vend_ack), .menu_option(menu_option),
        .vend_valid(vend_valid), .vend_item(vend_item), .gasto_out(gasto_out),
        .troco_out(troco_out), .deny(deny)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (deny === 1'b1) deny_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // b: 0=cima 1=baixo 2=enter; held across several ticks then released long enough to re-arm.
    task automatic press(input int b, input int hold_ticks);
        @(negedge clock);
        case (b)
            0: cima = 1'b0;
            1: baixo = 1'b0;
            default: enter = 1'b1;
        endcase
        repeat (hold_ticks * 4 + 4) @(negedge clock);
        cima = 1'b1; baixo = 1'b1; enter = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic step(input int b);
        press(b, 1);
        if (b == 0) idx_m = (idx_m + 1) % 4;
        else        idx_m = (idx_m + 3) % 4;
    endtask

    task automatic go_to(input int target);
        while (idx_m != target) step(0);
    endtask

    task automatic ack_pulse();
        @(negedge clock); vend_ack = 1'b1;
        @(negedge clock); vend_ack = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(vend_valid), 0);
        chk({tag, "_item"},  32'(vend_item), 0);
        chk({tag, "_gasto"}, 32'(gasto_out), 0);
        chk({tag, "_troco"}, 32'(troco_out), 0);
    endtask

    task automatic buy(input string tag, input int saldo);
        int d0;
        int price;
        price = price_m[idx_m];
        saldo_in = 6'(saldo);
        d0 = deny_cnt;
        press(2, 1);
        if (saldo >= price) begin
            chk({tag, "_valid"}, 32'(vend_valid), 1);
            chk({tag, "_item"},  32'(vend_item), 32'(1 << idx_m));
            chk({tag, "_gasto"}, 32'(gasto_out), 32'(price));
            chk({tag, "_troco"}, 32'(troco_out), 32'(saldo - price));
            chk({tag, "_nodeny"}, 32'(deny_cnt - d0), 0);
            ack_pulse();
            chk_idle({tag, "_ack"});
        end else begin
            chk({tag, "_deny"}, 32'(deny_cnt - d0), 1);
            chk({tag, "_novalid"}, 32'(vend_valid), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_menu", 32'(menu_option), 1);
        chk_idle("rst");
        chk("rst_deny", 32'(deny), 0);
        reset = 1'b0;

        // Held cima for 3 ticks steps exactly once.
        press(0, 3);
        idx_m = 1;
        chk("held_cima", 32'(menu_option), 4'b0010);

        step(1);
        chk("baixo_1", 32'(menu_option), 32'(1 << idx_m));
        step(1);
        chk("baixo_wrap", 32'(menu_option), 4'b1000);
        step(0);
        chk("cima_wrap", 32'(menu_option), 4'b0001);

        for (int i = 0; i < 10; i++) begin
            step(int'($urandom_range(1, 0)));
            chk("walk", 32'(menu_option), 32'(1 << idx_m));
        end

        // Exact-balance grant holds until ack.
        go_to(1);
        saldo_in = 6'd40;
        press(2, 1);
        chk("g40_valid", 32'(vend_valid), 1);
        chk("g40_item",  32'(vend_item), 4'b0010);
        chk("g40_gasto", 32'(gasto_out), 40);
        chk("g40_troco", 32'(troco_out), 0);
        repeat (6) @(negedge clock);
        chk("g40_hold",  32'(vend_valid), 1);
        chk("g40_hold_item", 32'(vend_item), 4'b0010);
        ack_pulse();
        chk_idle("g40_ack");

        go_to(0);
        buy("deny44", 44);

        for (int i = 0; i < 6; i++) begin
            go_to(int'($urandom_range(3, 0)));
            buy("rnd_buy", int'($urandom_range(50, 20)));
        end

        // Grant is frozen against buttons and balance; held cima does not fire after ack.
        go_to(3);
        saldo_in = 6'd50;
        press(2, 1);
        chk("frz_troco0", 32'(troco_out), 25);
        @(negedge clock);
        cima = 1'b0;
        saldo_in = 6'd0;
        repeat (12) @(negedge clock);
        chk("frz_menu",  32'(menu_option), 4'b1000);
        chk("frz_troco", 32'(troco_out), 25);
        chk("frz_valid", 32'(vend_valid), 1);
        ack_pulse();
        chk("frz_ack", 32'(vend_valid), 0);
        repeat (12) @(negedge clock);
        chk("frz_noStep", 32'(menu_option), 4'b1000);
        cima = 1'b1;
        repeat (12) @(negedge clock);

        // Reset mid-grant clears without ack.
        go_to(2);
        saldo_in = 6'd63;
        press(2, 1);
        chk("rg_valid", 32'(vend_valid), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rg_menu", 32'(menu_option), 1);
        chk_idle("rg");
        reset = 1'b0;
        idx_m = 0;
        step(0);
        chk("post_rst_step", 32'(menu_option), 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/menu_select_n.md
# menu_select_n

Parametrised food-machine menu controller. Navigates N items with up/down buttons and vends on enter when the balance covers the selected price. Each grant is held through a valid/ack handshake to the dispensing/payment logic. It succeeds the fixed four-item menu and adds:
- configurable item count, prices and money width
- press-edge (not level) button handling
- explicit denial pulse and computed change

## Interface
Parameters:
- N_ITEMS, 4: number of menu items (2..16)
- MONEY_W, 6: width of balance, price, spend and change values
- PRICES, {25,30,40,45}: packed N_ITEMS×MONEY_W vector; item i price at bits [i*MONEY_W +: MONEY_W] (item0=45, item1=40, item2=30, item3=25)
- TICK_BITS, 24: button sample tick period = 2**TICK_BITS clocks

Ports:
- clock, in, 1: sole clock
- reset, in, 1: synchronous, active-high
- cima, in, 1: "next" button, active-low, asynchronous to clock
- baixo, in, 1: "previous" button, active-low, asynchronous
- enter, in, 1: "buy" button, active-high, asynchronous
- saldo_in, in, MONEY_W: current customer balance, unsigned
- vend_ack, in, 1: consumer accepts grant
- menu_option, out, N_ITEMS: one-hot selected item
- vend_valid, out, 1: grant pending
- vend_item, out, N_ITEMS: one-hot granted item, 0 when not valid
- gasto_out, out, MONEY_W: price charged, 0 when not valid
- troco_out, out, MONEY_W: saldo_in − price captured at grant, 0 when not valid
- deny, out, 1: one-clock pulse on a refused purchase

## Operation
- Reset (sync, every output registered):
  - index=0, menu_option=1
  - vend_valid=0, vend_item=0, gasto_out=0, troco_out=0, deny=0
  - tick counter=0, button history=released
  - state=BROWSE
- Button conditioning:
  - each button passes through a 2-flop synchroniser and is normalised to active-high "pressed"
  - on tick, the sample is compared with the previous tick's sample
  - event = pressed now and released at the previous tick
  - a held button produces exactly one event
- Event priority within one tick: cima > baixo > enter. Lower-priority events in that tick are discarded.
- BROWSE:
  - cima event: index ← index+1, wrapping N_ITEMS−1→0
  - baixo event: index ← index−1, wrapping 0→N_ITEMS−1
  - enter event with saldo_in ≥ PRICES[index] (unsigned, equality grants):
    - load vend_item=onehot(index), gasto_out=price, troco_out=saldo_in−price, vend_valid=1
    - go to GRANT
  - enter event with saldo_in < price: deny=1 for one clock; stay in BROWSE
- GRANT:
  - outputs frozen; saldo_in changes do not affect troco_out
  - button events are consumed and ignored, but history keeps updating, so a button held across the grant does not fire on return
  - vend_ack=1 sampled on a clock edge: clear vend_valid, vend_item, gasto_out and troco_out; go to BROWSE
  - vend_ack is level-sampled every clock, independent of tick; vend_ack in BROWSE is ignored
- menu_option always equals onehot(index) and is updated in the same edge as index.
- States: BROWSE, GRANT. The encoding must be safe: an illegal state returns to BROWSE with all vend outputs cleared.

## Timing
- Tick:
  - one-clock pulse when the free-running TICK_BITS counter wraps
  - first tick occurs 2**TICK_BITS clocks after reset release
- Button-to-action latency: ≤ 2 (synchroniser) + 2**TICK_BITS clocks. The action is visible one clock after the tick edge.
- Grant: vend_valid rises 1 clock after the enter-event tick edge. vend_valid falls 1 clock after the vend_ack edge. Minimum valid width is 1 clock, if ack is already high.
- deny asserts 1 clock after its tick edge, for exactly 1 clock.
- Reset during GRANT drops vend_valid on the next edge with no ack required. Reset wins over every other event in the same cycle.
- Tick coincident with vend_ack in GRANT: the ack is processed; button events in that tick are ignored.

## Structure
- Package menu_pkg:
  - state enum
  - default price vector constant
  - onehot function
- Sub-module button_cond:
  - instantiated once, with width 3
  - contains the synchroniser, the tick-gated sample register and the edge detector
  - outputs per-button single-clock event pulses
  - the tick counter lives in menu_select_n and is passed to button_cond as an input

## Test plan
Run with TICK_BITS=2, defaults otherwise.
- Reset, then cima pressed for 3 ticks -> menu_option 0001→0010 once only; the held press does not re-step.
- From index0: baixo once -> menu_option=1000 (wrap). Then cima once -> 0001.
- Index1 (40), saldo_in=40, enter -> vend_valid=1, vend_item=0010, gasto_out=40, troco_out=0. These hold while vend_ack=0, and all clear 1 clock after vend_ack=1.
- Index0 (45), saldo_in=44, enter -> deny pulse 1 clock; vend_valid stays 0; state stays BROWSE.
- During GRANT (saldo 50, item3: troco 25): toggle cima and change saldo_in to 0 -> menu_option and troco_out unchanged. After ack, still holding cima -> no step.
- Assert reset mid-GRANT -> next edge: vend_valid=0, menu_option=0001, all money outputs 0.
